// File: rtl/conv_layer_pkg.sv
// ---------------------------------------------------------------------------
// conv_layer_pkg
// Command and ack encodings shared by the conv-layer input controller and the
// input interface, so both ends of the handshake use one encoding.
// ---------------------------------------------------------------------------
package conv_layer_pkg;

    localparam int unsigned CODE_W = 2;

    // Controller -> input interface command
    typedef enum logic [CODE_W-1:0] {
        CMD_IDLE    = 2'd0,
        CMD_PRELOAD = 2'd1,
        CMD_SHIFT   = 2'd2,
        CMD_LOAD    = 2'd3
    } cmd_e;

    // Input interface -> controller completion code
    typedef enum logic [CODE_W-1:0] {
        ACK_IDLE        = 2'd0,
        ACK_PRELOAD_FIN = 2'd1,
        ACK_SHIFT_FIN   = 2'd2,
        ACK_LOAD_FIN    = 2'd3
    } ack_e;

    // Completion code that closes a given command
    function automatic ack_e fin_for_cmd(input cmd_e c);
        case (c)
            CMD_PRELOAD: return ACK_PRELOAD_FIN;
            CMD_SHIFT:   return ACK_SHIFT_FIN;
            CMD_LOAD:    return ACK_LOAD_FIN;
            default:     return ACK_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/conv_ack_watchdog.sv
// ---------------------------------------------------------------------------
// conv_ack_watchdog
// Counts consecutive cycles spent waiting for an ack and flags the cycle in
// which the wait reaches TIMEOUT cycles.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the count (driven the cycle before a wait begins)
//   en         : a wait is in progress this cycle
//   expired    : combinational; high in the TIMEOUT-th waiting cycle
// ---------------------------------------------------------------------------
module conv_ack_watchdog #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    // r_cnt holds the number of waiting cycles already completed
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The current cycle is the TIMEOUT-th one when LAST cycles are already done
    assign expired = en && (r_cnt == LAST);

endmodule

// File: rtl/conv_layer_input_ctrl.sv
// ---------------------------------------------------------------------------
// conv_layer_input_ctrl
// Sequences one frame on the conv-layer input interface:
// PRELOAD, then SHIFT / LOAD alternating, ending with the last SHIFT.
// Each command is a one-cycle pulse; the controller then waits for the
// matching ack, going sticky-error on a wrong ack or a watchdog timeout.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : frame request pulse (honoured only when idle)
//   abort      : return to idle from any state, clears err
//   ack        : completion code from the input interface
//   cmd        : command pulse to the input interface
//   if_enable  : interface enable, same as busy
//   busy       : frame in progress
//   done       : one-cycle frame-complete pulse
//   err        : sticky protocol / timeout error
//   row_idx    : output row currently being shifted
// ---------------------------------------------------------------------------
module conv_layer_input_ctrl
    import conv_layer_pkg::*;
#(
    parameter int unsigned OUT_ROWS = 3,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [CODE_W-1:0]             ack,
    output logic [CODE_W-1:0]             cmd,
    output logic                          if_enable,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(OUT_ROWS+1)-1:0] row_idx
);

    localparam int unsigned ROW_W = $clog2(OUT_ROWS + 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_ROWS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE_REQ,
        S_PRE_WAIT,
        S_SHF_REQ,
        S_SHF_WAIT,
        S_LD_REQ,
        S_LD_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    state_e           r_state;
    cmd_e             r_cmd;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [ROW_W-1:0] r_row;

    logic w_in_wait;
    logic w_in_req;
    logic w_expired;
    ack_e w_pending_fin;
    logic w_ack_match;
    logic w_ack_bad;

    assign w_in_wait = (r_state == S_PRE_WAIT) || (r_state == S_SHF_WAIT) || (r_state == S_LD_WAIT);
    assign w_in_req  = (r_state == S_PRE_REQ)  || (r_state == S_SHF_REQ)  || (r_state == S_LD_REQ);

    // Ack code that completes the request currently outstanding
    always_comb begin
        w_pending_fin = ACK_IDLE;
        case (r_state)
            S_PRE_WAIT: w_pending_fin = fin_for_cmd(CMD_PRELOAD);
            S_SHF_WAIT: w_pending_fin = fin_for_cmd(CMD_SHIFT);
            S_LD_WAIT:  w_pending_fin = fin_for_cmd(CMD_LOAD);
            default:    w_pending_fin = ACK_IDLE;
        endcase
    end

    assign w_ack_match = w_in_wait && (ack == w_pending_fin);
    assign w_ack_bad   = w_in_wait && (ack != ACK_IDLE) && !w_ack_match;

    // Cleared during the request cycle so each wait starts counting from zero
    conv_ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_in_req),
        .en      (w_in_wait),
        .expired (w_expired)
    );

    // Frame sequencer with registered outputs; cmd and done default to
    // inactive every cycle so they can only ever pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cmd   <= CMD_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_row   <= '0;
        end else begin
            r_cmd  <= CMD_IDLE;
            r_done <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state <= S_PRE_REQ;
                            r_busy  <= 1'b1;
                            r_row   <= '0;
                        end
                    end
                    S_PRE_REQ: begin
                        r_state <= S_PRE_WAIT;
                        r_cmd   <= CMD_PRELOAD;
                    end
                    S_SHF_REQ: begin
                        r_state <= S_SHF_WAIT;
                        r_cmd   <= CMD_SHIFT;
                    end
                    S_LD_REQ: begin
                        r_state <= S_LD_WAIT;
                        r_cmd   <= CMD_LOAD;
                    end
                    S_PRE_WAIT, S_SHF_WAIT, S_LD_WAIT: begin
                        // A matching ack wins even in the cycle the watchdog expires
                        if (w_ack_match) begin
                            if (r_state == S_PRE_WAIT) begin
                                r_state <= S_SHF_REQ;
                            end else if (r_state == S_SHF_WAIT) begin
                                if (r_row == LAST_ROW) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= S_LD_REQ;
                                end
                            end else begin
                                r_state <= S_SHF_REQ;
                                r_row   <= r_row + ROW_W'(1);
                            end
                        end else if (w_ack_bad || w_expired) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    S_ERR: begin
                        r_state <= S_ERR;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cmd       = r_cmd;
    assign busy      = r_busy;
    assign if_enable = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign row_idx   = r_row;

endmodule
